// File: rtl/window_serializer.sv
// Ring line buffer + serializer feeding 3x3 windows, one tap per cycle, to the conv stage.
// Optional build macro WIN_STRIDE2_EN: only windows with even top-left row/column are emitted.
module window_serializer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [DW-1:0] pix_data,
    output logic          win_start,
    output logic          data_vld,
    output logic [DW-1:0] data_out,
    output logic [7:0]    win_row,
    output logic [7:0]    win_col,
    input  logic          conv_done,
    output logic          frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {ACCEPT, START, SEND, WAIT} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_mem [3][IMG_W];
    logic [CW-1:0] r_col, r_wcol, w_tcol;
    logic [RW-1:0] r_row;
    logic [1:0]    r_slot, r_wslot, w_slot_inc, w_ti, w_tj, w_tslot;
    logic [2:0]    w_ssum;
    logic [3:0]    r_tap, w_nidx;
    logic          r_ready, r_win_start, r_data_vld, r_frame_done, r_last_win;
    logic [DW-1:0] r_data_out, w_tap;
    logic [7:0]    r_win_row, r_win_col;
    logic          w_hs, w_last_col, w_last_row, w_last_pix, w_win;

    assign pix_ready  = r_ready;
    assign win_start  = r_win_start;
    assign data_vld   = r_data_vld;
    assign data_out   = r_data_out;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

    assign w_hs       = pix_valid && r_ready;
    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));
    assign w_last_pix = w_last_col && w_last_row;
    // (r-2) mod 3 equals (r+1) mod 3, i.e. the slot after the one being written
    assign w_slot_inc = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;

`ifdef WIN_STRIDE2_EN
    assign w_win = (r_row >= RW'(2)) && (r_col >= CW'(2)) && !r_row[0] && !r_col[0];
`else
    assign w_win = (r_row >= RW'(2)) && (r_col >= CW'(2));
`endif

    // Address of the tap that goes out on the next clock edge
    always_comb begin
        w_nidx = (r_state == START) ? 4'd0 : r_tap + 4'd1;
        w_ti   = 2'd2;
        w_tj   = 2'd2;
        case (w_nidx)
            4'd0, 4'd1, 4'd2: w_ti = 2'd0;
            4'd3, 4'd4, 4'd5: w_ti = 2'd1;
            default:          w_ti = 2'd2;
        endcase
        case (w_nidx)
            4'd0, 4'd3, 4'd6: w_tj = 2'd0;
            4'd1, 4'd4, 4'd7: w_tj = 2'd1;
            default:          w_tj = 2'd2;
        endcase
        w_ssum  = {1'b0, r_wslot} + {1'b0, w_ti};
        w_tslot = (w_ssum >= 3'd3) ? 2'(w_ssum - 3'd3) : w_ssum[1:0];
        w_tcol  = r_wcol + CW'(w_tj);
        w_tap   = r_mem[w_tslot][w_tcol];
    end

    always_ff @(posedge clk) begin
        if (w_hs) r_mem[r_slot][r_col] <= pix_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ACCEPT;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCEPT: if (w_hs && w_win) w_next = START;
            START:  w_next = SEND;
            SEND:   if (r_tap == 4'd8) w_next = WAIT;
            WAIT:   if (conv_done) w_next = ACCEPT;
            default: w_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready      <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_slot       <= '0;
            r_tap        <= '0;
            r_wslot      <= '0;
            r_wcol       <= '0;
            r_last_win   <= 1'b0;
            r_win_start  <= 1'b0;
            r_data_vld   <= 1'b0;
            r_data_out   <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_ready      <= (w_next == ACCEPT);
            r_win_start  <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_hs) begin
                if (w_last_col) begin
                    r_col <= '0;
                    if (w_last_row) begin
                        r_row  <= '0;
                        r_slot <= '0;
                    end else begin
                        r_row  <= r_row + RW'(1);
                        r_slot <= w_slot_inc;
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (w_win) begin
                    r_win_start <= 1'b1;
                    r_win_row   <= 8'(r_row) - 8'd2;
                    r_win_col   <= 8'(r_col) - 8'd2;
                    r_wslot     <= w_slot_inc;
                    r_wcol      <= r_col - CW'(2);
                    r_last_win  <= w_last_pix;
                end else if (w_last_pix) begin
                    r_frame_done <= 1'b1;
                end
            end
            case (r_state)
                START: begin
                    r_data_vld <= 1'b1;
                    r_data_out <= w_tap;
                    r_tap      <= 4'd0;
                end
                SEND: begin
                    if (r_tap == 4'd8) begin
                        r_data_vld <= 1'b0;
                        r_tap      <= 4'd0;
                    end else begin
                        r_data_out <= w_tap;
                        r_tap      <= r_tap + 4'd1;
                    end
                end
                WAIT: begin
                    if (conv_done && r_last_win) begin
                        r_frame_done <= 1'b1;
                        r_last_win   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer: frame-level window model checked every cycle, plus literal pins.
module tb_window_serializer;
`ifdef WIN_STRIDE2_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif
    localparam int DW = 12;

    logic          clk = 1'b0, rst = 1'b0, pix_valid = 1'b0, conv_done = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready, win_start, data_vld, frame_done;
    logic [DW-1:0] data_out;
    logic [7:0]    win_row, win_col;

    window_serializer #(.IMG_W(N), .IMG_H(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .win_start(win_start), .data_vld(data_vld),
        .data_out(data_out), .win_row(win_row), .win_col(win_col),
        .conv_done(conv_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int asserts = 0, fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: image seen so far, raster position, and cycle offset since the window-completing pixel
    int img [N][N];
    int mr = 0, mc = 0, phase = 0, wr = 0, wc = 0;
    int wtap [9];
    bit exp_fd = 0, prev_rst_low = 1, cur_last = 0, exp_rdy;
    int ncap = 0, ktap = 9, fd_count = 0, cd_delay = 0, rn;
    int cap_row [32], cap_col [32];
    int cap_tap [32][9];

    function automatic bit qualifies(input int r, input int c);
`ifdef WIN_STRIDE2_EN
        return r >= 2 && c >= 2 && (r % 2) == 0 && (c % 2) == 0;
`else
        return r >= 2 && c >= 2;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_pix_ready", int'(pix_ready), 0);
            chk("rst_win_start", int'(win_start), 0);
            chk("rst_data_vld", int'(data_vld), 0);
            chk("rst_data_out", int'(data_out), 0);
            chk("rst_win_row", int'(win_row), 0);
            chk("rst_win_col", int'(win_col), 0);
            chk("rst_frame_done", int'(frame_done), 0);
            phase = 0; mr = 0; mc = 0; exp_fd = 0; prev_rst_low = 1; ktap = 9;
        end else begin
            exp_rdy = (phase == 0) && !prev_rst_low;
            chk("pix_ready", int'(pix_ready), int'(exp_rdy));
            chk("win_start", int'(win_start), int'(phase == 1));
            chk("data_vld", int'(data_vld), int'(phase >= 2 && phase <= 10));
            chk("frame_done", int'(frame_done), int'(exp_fd));
            if (phase == 1) begin
                chk("win_row", int'(win_row), wr);
                chk("win_col", int'(win_col), wc);
            end
            if (phase >= 2 && phase <= 10) chk("data_out", int'(data_out), wtap[phase-2]);
            if (win_start && ncap < 32) begin
                cap_row[ncap] = int'(win_row);
                cap_col[ncap] = int'(win_col);
                ncap++;
                ktap = 0;
            end else if (data_vld && ncap > 0 && ktap < 9) begin
                cap_tap[ncap-1][ktap] = int'(data_out);
                ktap++;
            end
            if (frame_done) fd_count++;
            exp_fd = 0;
            if (phase == 0) begin
                if (exp_rdy && pix_valid) begin
                    img[mr][mc] = int'(pix_data);
                    if (qualifies(mr, mc)) begin
                        wr = mr - 2; wc = mc - 2;
                        for (int k = 0; k < 9; k++) wtap[k] = img[wr + k/3][wc + k%3];
                        cur_last = (mr == N-1) && (mc == N-1);
                        phase = 1;
                    end else if (mr == N-1 && mc == N-1) begin
                        exp_fd = 1;
                    end
                    if (mc == N-1) begin
                        mc = 0;
                        mr = (mr == N-1) ? 0 : mr + 1;
                    end else begin
                        mc++;
                    end
                end
            end else if (phase < 11) begin
                phase++;
            end else if (conv_done) begin
                phase = 0;
                exp_fd = cur_last;
            end
            prev_rst_low = 0;
        end
    end

    // Conv-stage stand-in: reports completion cd_delay cycles after the taps end
    initial begin
        forever begin
            @(negedge clk);
            if (win_start && rst) begin
                rn = 0;
                @(negedge clk);
                while (data_vld && rn < 50) begin
                    @(negedge clk);
                    rn++;
                end
                repeat (cd_delay + 1) @(posedge clk);
                #1 conv_done = 1'b1;
                @(posedge clk);
                #1 conv_done = 1'b0;
            end
        end
    end

    task automatic send_pixel(input int v, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 9) < 3) begin
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b1;
        pix_data  = DW'(v);
        n = 0;
        @(negedge clk);
        while (!pix_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            asserts++; fails++;
            $display("FAIL pixel_accept_timeout: pix_ready=0, expected 1");
        end
        @(posedge clk);
        #1 pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((phase != 0 || exp_fd) && n < 300) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (n >= 300) begin
            fails++;
            $display("FAIL idle_timeout: model phase %0d, expected 0", phase);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input int step, input bit gaps);
        for (int n = 0; n < N*N; n++) send_pixel(base + step*n, gaps);
        wait_idle();
    endtask

    task automatic chk_win(input string name, input int w, input int e[9]);
        for (int k = 0; k < 9; k++) chk(name, cap_tap[w][k], e[k]);
    endtask

    int n0;
`ifndef WIN_STRIDE2_EN
    int e_w00 [9] = '{'h000, 'h010, 'h020, 'h040, 'h050, 'h060, 'h080, 'h090, 'h0A0};
    int e_w11 [9] = '{'h050, 'h060, 'h070, 'h090, 'h0A0, 'h0B0, 'h0D0, 'h0E0, 'h0F0};
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
`ifndef WIN_STRIDE2_EN
        // Frame 1: continuous valid, immediate conv_done
        send_frame('h000, 'h010, 1'b0);
        chk("f1_windows", ncap, 4);
        chk_win("f1_win00_tap", 0, e_w00);
        chk_win("f1_win11_tap", 3, e_w11);
        chk("f1_win3_row", cap_row[3], 1);
        chk("f1_win3_col", cap_col[3], 1);
        chk("f1_frame_done", fd_count, 1);
        // Frame 2 back-to-back, conv_done held off 20 cycles after each window
        cd_delay = 20;
        send_frame('h100, 'h010, 1'b0);
        chk("f2_windows", ncap, 8);
        chk("f2_win0_tap0", cap_tap[4][0], 'h100);
        chk("f2_win0_row", cap_row[4], 0);
        chk("f2_win0_col", cap_col[4], 0);
        chk("f2_frame_done", fd_count, 2);
        // Reset during tap 4 of the first window
        cd_delay = 0;
        for (int n = 0; n < 11; n++) send_pixel('h010*n, 1'b0);
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_data_out", int'(data_out), 'h050);
        rst = 1'b0;
        #1 chk("async_rst_data_vld", int'(data_vld), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        n0 = ncap;
        send_frame('h007, 'h005, 1'b0);
        chk("rst_frame_windows", ncap - n0, 4);
        chk("rst_frame_tap0", cap_tap[n0][0], 'h007);
        chk("rst_frame_done", fd_count, 3);
        // Random idle gaps: same tap sequence as frame 1
        n0 = ncap;
        send_frame('h000, 'h010, 1'b1);
        chk("gap_windows", ncap - n0, 4);
        chk_win("gap_win00_tap", n0, e_w00);
        chk_win("gap_win11_tap", n0 + 3, e_w11);
`else
        send_frame('h000, 'h010, 1'b0);
        chk("s2_windows", ncap, 4);
        chk("s2_w0_row", cap_row[0], 0); chk("s2_w0_col", cap_col[0], 0);
        chk("s2_w1_row", cap_row[1], 0); chk("s2_w1_col", cap_col[1], 2);
        chk("s2_w2_row", cap_row[2], 2); chk("s2_w2_col", cap_col[2], 0);
        chk("s2_w3_row", cap_row[3], 2); chk("s2_w3_col", cap_col[3], 2);
        chk("s2_w1_tap0", cap_tap[1][0], 'h020);
        chk("s2_w3_tap8", cap_tap[3][8], 'h180);
        chk("s2_frame_done", fd_count, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
